fetch_queue: RTL and testbench



---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue_if.sv | 34 +++
 rtl/fetch_queue_ram.sv | 29 ++
 rtl/fetch_queue.sv | 83 ++++++++
 tb/tb_fetch_queue.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package fetch_pkg;

  // Default datapath width for PC, NPC and instruction fields.
  localparam int XLEN_DEFAULT = 32;

  // Canonical RISC-V NOP (addi x0, x0, 0) presented when the queue is empty.
  localparam logic [XLEN_DEFAULT-1:0] INSTR_NOP = 32'h0000_0013;

  // One fetched bundle as stored in the queue.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] npc;
    logic [XLEN_DEFAULT-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of fetch-side, decode-side and control signals around the fetch queue.
// master = the surrounding pipeline (drives fetch/branch/hazard inputs),
// slave  = the queue itself.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);

  logic                     if_valid_in;
  logic [XLEN-1:0]          if_PC_in;
  logic [XLEN-1:0]          if_NPC_in;
  logic [XLEN-1:0]          if_IR_in;
  logic                     fq_ready;
  logic                     ex_take_branch_out;
  logic                     d_hazard_detected;
  logic                     id_valid_out;
  logic [XLEN-1:0]          id_PC_out;
  logic [XLEN-1:0]          id_NPC_out;
  logic [XLEN-1:0]          id_IR_out;
  logic [$clog2(DEPTH):0]   fq_count;

  modport master (
    output if_valid_in, if_PC_in, if_NPC_in, if_IR_in,
    output ex_take_branch_out, d_hazard_detected,
    input  fq_ready, id_valid_out, id_PC_out, id_NPC_out, id_IR_out, fq_count
  );

  modport slave (
    input  if_valid_in, if_PC_in, if_NPC_in, if_IR_in,
    input  ex_take_branch_out, d_hazard_detected,
    output fq_ready, id_valid_out, id_PC_out, id_NPC_out, id_IR_out, fq_count
  );

endinterface

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: clocked write port, asynchronous read
// port so the head entry is visible to decode in the same cycle. No reset:
// validity is tracked entirely by the pointers/count in the parent.
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [PW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [PW-1:0] raddr,
  output fetch_entry_t rdata
);

  fetch_entry_t mem [DEPTH];

  // Write the pushed bundle at the tail slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling queue between fetch and decode. Fetch pushes one bundle per
// cycle while there is room; decode pops the head unless it reports a hazard.
// A taken branch empties the queue in one cycle and drops the wrong-path push.
// XLEN must match fetch_pkg::XLEN_DEFAULT since entries are stored as
// fetch_entry_t.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  fetch_queue_if.slave fq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;

  logic ready, valid, push, pop, flush;
  fetch_entry_t wr_entry, rd_entry;

  // Handshake qualifiers depend only on registered state plus inputs;
  // ready never looks at the decode hazard.
  assign flush = fq.ex_take_branch_out;
  assign ready = (count_reg < FULL_COUNT);
  assign valid = (count_reg != '0);
  assign push  = fq.if_valid_in & ready & ~flush;
  assign pop   = valid & ~fq.d_hazard_detected & ~flush;

  assign wr_entry = '{pc: fq.if_PC_in, npc: fq.if_NPC_in, ir: fq.if_IR_in};

  fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (tail_reg),
    .wdata (wr_entry),
    .raddr (head_reg),
    .rdata (rd_entry)
  );

  // Next pointer/count: flush overrides any push or pop in the same cycle.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (push) tail_next = tail_reg + PW'(1);
      if (pop)  head_next = head_reg + PW'(1);
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  // Pointer and occupancy registers; reset empties the queue immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  assign fq.fq_ready     = ready;
  assign fq.fq_count     = count_reg;
  assign fq.id_valid_out = valid;
  assign fq.id_PC_out    = valid ? rd_entry.pc  : '0;
  assign fq.id_NPC_out   = valid ? rd_entry.npc : '0;
  assign fq.id_IR_out    = valid ? rd_entry.ir  : INSTR_NOP;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized plus directed bench for fetch_queue, checked against a queue model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ir;
  } bundle_t;

  logic clk;
  logic rst_n;
  int   checks_total;
  int   checks_passed;
  int   cyc;
  bundle_t model_q[$];

  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) fq_bus ();

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fq    (fq_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got !== exp) begin
      $display("FAIL %s cyc=%0d: got %h, expected %h", tag, cyc, got, exp);
    end else begin
      checks_passed++;
    end
  endtask

  // Compare every DUT output with what the model queue says it must be.
  task automatic check_outputs();
    int n;
    n = model_q.size();
    check("count", 64'(fq_bus.fq_count), 64'(n));
    check("ready", 64'(fq_bus.fq_ready), 64'(n < DEPTH));
    check("valid", 64'(fq_bus.id_valid_out), 64'(n != 0));
    check("pc",  64'(fq_bus.id_PC_out),  64'((n != 0) ? model_q[0].pc  : 32'h0));
    check("npc", 64'(fq_bus.id_NPC_out), 64'((n != 0) ? model_q[0].npc : 32'h0));
    check("ir",  64'(fq_bus.id_IR_out),  64'((n != 0) ? model_q[0].ir  : NOP));
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge,
  // then apply the queue rules to the model at the rising edge.
  task automatic cycle(input logic valid, input logic [31:0] pc,
                       input logic hazard, input logic flush);
    bundle_t b;
    int n;
    logic do_push, do_pop;
    b.pc  = pc;
    b.npc = pc + 32'd4;
    b.ir  = $urandom;
    fq_bus.if_valid_in        = valid;
    fq_bus.if_PC_in           = b.pc;
    fq_bus.if_NPC_in          = b.npc;
    fq_bus.if_IR_in           = b.ir;
    fq_bus.d_hazard_detected  = hazard;
    fq_bus.ex_take_branch_out = flush;
    @(negedge clk);
    check_outputs();
    $display("cyc %0d: v=%0b pc=%h hz=%0b fl=%0b | cnt=%0d rdy=%0b head_v=%0b head_pc=%h",
             cyc, valid, pc, hazard, flush, fq_bus.fq_count, fq_bus.fq_ready,
             fq_bus.id_valid_out, fq_bus.id_PC_out);
    @(posedge clk);
    n = model_q.size();
    if (flush) begin
      model_q.delete();
    end else begin
      do_push = valid && (n < DEPTH);
      do_pop  = (n != 0) && !hazard;
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(b);
    end
    cyc++;
    #1;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    cyc = 0;
    rst_n = 1'b0;
    fq_bus.if_valid_in        = 1'b0;
    fq_bus.if_PC_in           = '0;
    fq_bus.if_NPC_in          = '0;
    fq_bus.if_IR_in           = '0;
    fq_bus.d_hazard_detected  = 1'b0;
    fq_bus.ex_take_branch_out = 1'b0;

    // Outputs while held in reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill with decode stalled, then drain in order.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Stream 16 bundles through with a pop every cycle, across pointer wraps.
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'(i * 4), 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Flush while full with a wrong-path push, then a fresh push.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h40 + 32'(i * 4), 1'b1, 1'b0);
    cycle(1'b1, 32'h100, 1'b1, 1'b1);
    cycle(1'b1, 32'h200, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Push and pop offered together while full: only the pop happens.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h300 + 32'(i * 4), 1'b1, 1'b0);
    cycle(1'b1, 32'h400, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges with three entries queued.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(fq_bus.id_valid_out), 64'(0));
    check("async_rst_count", 64'(fq_bus.fq_count), 64'(0));
    model_q.delete();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 99) < 70, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 8);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
